// File: rtl/dmem_responder_if.sv
// ============================================================================
// Module      : dmem_responder_if
// Description : Memory-stage request/response bundle between pipeline and
//               the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        busy;

    modport master (output req, we, addr, wdata, input rdata, ack, busy);
    modport slave  (input req, we, addr, wdata, output rdata, ack, busy);
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Wait-state data-memory responder with RAM, SW/LED I/O and an
//               optional cycle counter enabled by DMEM_CYCLE_COUNTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
    parameter int WORDS = 64,
    parameter int WAIT  = 1
) (
    input  wire logic        clk,
    input  wire logic        reset,
    dmem_responder_if.slave  bus,
    input  wire logic [3:0]  SW,
    output logic      [7:0]  LED,
    output logic             fault
);

    localparam int         c_aw        = $clog2(WORDS);
    localparam logic [3:0] c_wait_init = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic [7:0]  led_q, led_d;
    logic        fault_q, fault_d;
`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] cyc_q, cyc_d;
`endif

    logic [31:0] mem [WORDS];

    logic        w_commit;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_is_ram, w_is_sw, w_is_led, w_is_cnt, w_bad;
    logic [31:0] w_rd_val;
    logic        w_ram_we;

    // With WAIT=0 the commit lands on the accept edge, so it must see the live request.
    assign w_we    = (state_q == S_IDLE) ? bus.we    : we_q;
    assign w_addr  = (state_q == S_IDLE) ? bus.addr  : addr_q;
    assign w_wdata = (state_q == S_IDLE) ? bus.wdata : wdata_q;

    assign w_is_ram = (w_addr[31:c_aw+2] == '0);
    assign w_is_sw  = (w_addr == 32'h0000_1000);
    assign w_is_led = (w_addr == 32'h0000_1004);
    assign w_is_cnt = (w_addr == 32'h0000_1008);
    assign w_bad    = (w_addr[1:0] != 2'b00) || !(w_is_ram || w_is_sw || w_is_led || w_is_cnt);

    always_comb begin
        w_rd_val = 32'd0;
        if (w_is_ram) begin
            w_rd_val = mem[w_addr[c_aw+1:2]];
        end else if (w_is_sw) begin
            w_rd_val = {28'd0, SW};
        end else if (w_is_led) begin
            w_rd_val = {24'd0, led_q};
`ifdef DMEM_CYCLE_COUNTER_EN
        end else if (w_is_cnt) begin
            w_rd_val = cyc_q;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ack_d    = 1'b0;
        led_d    = led_q;
        fault_d  = fault_q;
        w_commit = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    if (WAIT == 0) begin
                        state_d  = S_RESP;
                        w_commit = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = c_wait_init;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d  = S_RESP;
                    w_commit = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (w_commit) begin
            ack_d = 1'b1;
            if (w_bad) fault_d = 1'b1;
            if (!w_we) rdata_d = w_bad ? 32'd0 : w_rd_val;
            if (w_we && !w_bad && w_is_led) led_d = w_wdata[7:0];
        end
    end

`ifdef DMEM_CYCLE_COUNTER_EN
    assign cyc_d = (w_commit && w_we && !w_bad && w_is_cnt) ? 32'd0 : cyc_q + 32'd1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            ack_q   <= 1'b0;
            led_q   <= 8'd0;
            fault_q <= 1'b0;
`ifdef DMEM_CYCLE_COUNTER_EN
            cyc_q   <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            led_q   <= led_d;
            fault_q <= fault_d;
`ifdef DMEM_CYCLE_COUNTER_EN
            cyc_q   <= cyc_d;
`endif
        end
    end

    // RAM is not reset; an asserted reset still blocks a write on the same edge.
    assign w_ram_we = w_commit && w_we && !w_bad && w_is_ram && !reset;

    always_ff @(posedge clk) begin
        if (w_ram_we) mem[w_addr[c_aw+1:2]] <= w_wdata;
    end

    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
    assign bus.busy  = (state_q != S_IDLE);
    assign LED       = led_q;
    assign fault     = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench; one responder with WAIT=1 and
//               one with WAIT=0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sw = 4'hC;
    logic [7:0] led1, led0;
    logic       fault1, fault0;
    int         cyc = 0;
    int         nrun = 0;
    int         nfail = 0;

    dmem_responder_if bus1 ();
    dmem_responder_if bus0 ();

    dmem_responder #(.WORDS(64), .WAIT(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .SW(sw), .LED(led1), .fault(fault1)
    );
    dmem_responder #(.WORDS(64), .WAIT(0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .SW(sw), .LED(led0), .fault(fault0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nrun++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit d, input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd);
        if (d) begin
            bus1.req = r; bus1.we = w; bus1.addr = a; bus1.wdata = wd;
        end else begin
            bus0.req = r; bus0.we = w; bus0.addr = a; bus0.wdata = wd;
        end
    endtask

    function automatic logic ackv(input bit d);
        return d ? bus1.ack : bus0.ack;
    endfunction

    function automatic logic busyv(input bit d);
        return d ? bus1.busy : bus0.busy;
    endfunction

    // One access with req held high and addr/wdata scrambled after accept.
    task automatic acc(input bit d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output int ackc);
        int lat;
        drive(d, 1'b1, w, a, wd);
        @(posedge clk); #1;
        chk("busy_after_accept", {31'd0, busyv(d)}, 32'd1);
        drive(d, 1'b1, ~w, ~a, ~wd);
        lat = 0;
        while (!ackv(d) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ack_latency", 32'(lat), d ? 32'd1 : 32'd0);
        rd   = d ? bus1.rdata : bus0.rdata;
        ackc = cyc;
        @(posedge clk); #1;
        chk("ack_one_cycle", {31'd0, ackv(d)}, 32'd0);
        chk("no_accept_in_resp", {31'd0, busyv(d)}, 32'd0);
        drive(d, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int c0, c1;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_ack",   {31'd0, bus1.ack},  32'd0);
        chk("rst_busy",  {31'd0, bus1.busy}, 32'd0);
        chk("rst_rdata", bus1.rdata,         32'd0);
        chk("rst_led",   {24'd0, led1},      32'd0);
        chk("rst_fault", {31'd0, fault1},    32'd0);
        chk("rst_led0",  {24'd0, led0},      32'd0);

        // RAM store/load round trip
        acc(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, c0);
        acc(1'b1, 1'b0, 32'h10, 32'h0, rd, c0);
        chk("ram_load_10", rd, 32'hDEAD_BEEF);
        acc(1'b1, 1'b1, 32'h0, 32'h1234_5678, rd, c0);
        chk("store_keeps_rdata", rd, 32'hDEAD_BEEF);
        acc(1'b1, 1'b1, 32'h4, 32'h1111_2222, rd, c0);

        acc(1'b1, 1'b0, 32'h1000, 32'h0, rd, c0);
        chk("sw_read", rd, 32'h0000_000C);
        chk("sw_no_fault", {31'd0, fault1}, 32'd0);

        // Counter: cleared on the write commit edge, read on the load commit edge
        acc(1'b1, 1'b1, 32'h1008, 32'hFFFF_FFFF, rd, c0);
        acc(1'b1, 1'b0, 32'h1008, 32'h0, rd, c1);
`ifdef DMEM_CYCLE_COUNTER_EN
        chk("cnt_read", rd, 32'(c1 - c0 - 1));
`else
        chk("cnt_read", rd, 32'd0);
`endif
        chk("cnt_no_fault", {31'd0, fault1}, 32'd0);

        // Reset while a store sits in WAIT
        drive(1'b1, 1'b1, 1'b1, 32'h4, 32'h0000_0099);
        @(posedge clk); #1;
        chk("mid_busy", {31'd0, bus1.busy}, 32'd1);
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("mid_rst_busy", {31'd0, bus1.busy}, 32'd0);
        @(posedge clk); #1;
        chk("mid_rst_ack", {31'd0, bus1.ack}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_ack2", {31'd0, bus1.ack}, 32'd0);
        acc(1'b1, 1'b0, 32'h4, 32'h0, rd, c0);
        chk("aborted_store", rd, 32'h1111_2222);

        // Misaligned load faults but still acks; fault is sticky
        acc(1'b1, 1'b0, 32'h10, 32'h0, rd, c0);
        chk("preload", rd, 32'hDEAD_BEEF);
        acc(1'b1, 1'b0, 32'h2, 32'h0, rd, c0);
        chk("misalign_rdata", rd, 32'd0);
        chk("misalign_fault", {31'd0, fault1}, 32'd1);
        acc(1'b1, 1'b0, 32'h10, 32'h0, rd, c0);
        chk("good_after_fault", rd, 32'hDEAD_BEEF);
        chk("fault_sticky", {31'd0, fault1}, 32'd1);

        // Unmapped store just past the RAM must not alias onto word 0
        acc(1'b1, 1'b1, 32'h100, 32'h5555_5555, rd, c0);
        chk("unmapped_fault", {31'd0, fault1}, 32'd1);
        acc(1'b1, 1'b0, 32'h0, 32'h0, rd, c0);
        chk("ram0_intact", rd, 32'h1234_5678);

        // WAIT=0: back-to-back LED stores
        acc(1'b0, 1'b1, 32'h1004, 32'h0000_01A5, rd, c0);
        chk("led_first", {24'd0, led0}, 32'h0000_00A5);
        acc(1'b0, 1'b1, 32'h1004, 32'h0000_0003, rd, c1);
        chk("led_second", {24'd0, led0}, 32'h0000_0003);
        chk("ack_spacing", 32'(c1 - c0), 32'd2);
        acc(1'b0, 1'b0, 32'h1004, 32'h0, rd, c0);
        chk("led_read", rd, 32'h0000_0003);
        acc(1'b0, 1'b1, 32'h1000, 32'hFFFF_FFFF, rd, c0);
        chk("sw_write_no_fault", {31'd0, fault0}, 32'd0);
        acc(1'b0, 1'b0, 32'h1008, 32'h0, rd, c0);
`ifndef DMEM_CYCLE_COUNTER_EN
        chk("cnt_absent_read", rd, 32'd0);
`endif
        chk("cnt_absent_no_fault", {31'd0, fault0}, 32'd0);
        acc(1'b0, 1'b0, 32'h2000, 32'h0, rd, c0);
        chk("unmapped_rdata0", rd, 32'd0);
        chk("unmapped_fault0", {31'd0, fault0}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

endmodule

`default_nettype wire
